popcount_seq: RTL and testbench

POPCOUNT_SEQ -- requirements
Module: popcount_seq

---
 rtl/popcount_seq_if.sv | 25 ++
 rtl/popcount_seq.sv | 109 ++++++++++
 tb/tb_popcount_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/popcount_seq_if.sv
// Word-in / count-out handshake bundle for popcount_seq.
// master = producer/consumer side, slave = the counter block.
interface popcount_seq_if #(
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_zeros;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_zeros, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, in_zeros, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/popcount_seq.sv
// Sequential population counter: CHUNK_W bits per cycle over a latched DATA_W word.
// Optional running total of results when POPCOUNT_SEQ_ACCUM_EN is defined.
module popcount_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    popcount_seq_if.slave     bus
`ifdef POPCOUNT_SEQ_ACCUM_EN
    ,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] acc_total
`endif
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  word_q;
    logic [CNT_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               idle_rdy;
    logic               done_vld;
    logic               accept;
    logic               release_out;
    logic               last_chunk;

    function automatic logic [CNT_W-1:0] chunk_pop(input logic [CHUNK_W-1:0] c);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) n = n + CNT_W'(c[i]);
        return n;
    endfunction

    assign last_chunk  = (idx_q == IDX_W'(NCHUNK - 1));
    assign accept      = bus.in_valid && idle_rdy;
    assign release_out = done_vld && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idle_rdy = 1'b0;
        done_vld = 1'b0;
        case (state_q)
            IDLE: begin
                idle_rdy = 1'b1;
                if (bus.in_valid) state_d = COUNT;
            end
            COUNT: begin
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                done_vld = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted word leaves no residue behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            word_q <= bus.in_zeros ? ~bus.in_data : bus.in_data;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (state_q == COUNT) begin
            acc_q  <= acc_q + chunk_pop(word_q[CHUNK_W-1:0]);
            word_q <= word_q >> CHUNK_W;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign bus.in_ready  = idle_rdy;
    assign bus.out_valid = done_vld;
    // The partial sum is hidden until the word is finished.
    assign bus.out_count = (state_q == DONE) ? acc_q : '0;

`ifdef POPCOUNT_SEQ_ACCUM_EN
    logic [DATA_W:0] acc_sum;

    assign acc_sum = {1'b0, acc_total} + (DATA_W + 1)'(acc_q);

    // A clear coincident with a result restarts the total from that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_total <= '0;
        end else if (acc_clr) begin
            acc_total <= release_out ? DATA_W'(acc_q) : '0;
        end else if (release_out) begin
            acc_total <= acc_sum[DATA_W] ? '1 : acc_sum[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Directed self-checking bench for popcount_seq: 32/8, 8/1 and 8/8 instances.
// Running-total checks are included when POPCOUNT_SEQ_ACCUM_EN is defined.
module tb_popcount_seq;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    popcount_seq_if #(.DATA_W(32)) if_a ();
    popcount_seq_if #(.DATA_W(8))  if_b ();
    popcount_seq_if #(.DATA_W(8))  if_c ();

`ifdef POPCOUNT_SEQ_ACCUM_EN
    logic        acc_clr_a, acc_clr_b, acc_clr_c;
    logic [31:0] acc_total_a;
    logic [7:0]  acc_total_b, acc_total_c;
`endif

    popcount_seq #(.DATA_W(32), .CHUNK_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
`ifdef POPCOUNT_SEQ_ACCUM_EN
        , .acc_clr(acc_clr_a), .acc_total(acc_total_a)
`endif
    );

    popcount_seq #(.DATA_W(8), .CHUNK_W(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
`ifdef POPCOUNT_SEQ_ACCUM_EN
        , .acc_clr(acc_clr_b), .acc_total(acc_total_b)
`endif
    );

    popcount_seq #(.DATA_W(8), .CHUNK_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave)
`ifdef POPCOUNT_SEQ_ACCUM_EN
        , .acc_clr(acc_clr_c), .acc_total(acc_total_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a word for one edge, then scramble the inputs to prove they were latched.
    task automatic start_a(input logic [31:0] d, input logic z);
        if_a.in_valid = 1'b1;
        if_a.in_data  = d;
        if_a.in_zeros = z;
        tick(1);
        if_a.in_valid = 1'b0;
        if_a.in_data  = ~d;
        if_a.in_zeros = ~z;
    endtask

    // Cycles from acceptance to out_valid; busy_ok drops if COUNT shows in_ready or a count.
    task automatic wait_done_a(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!if_a.out_valid && cyc < 40) begin
            if (if_a.in_ready || if_a.out_count != 0) busy_ok = 1'b0;
            tick(1);
            cyc++;
        end
    endtask

    task automatic run_a(input logic [31:0] d, input logic z, input int exp, input string tag);
        int cyc;
        bit busy_ok;
        start_a(d, z);
        wait_done_a(cyc, busy_ok);
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_count"}, if_a.out_count, exp);
        check({tag, "_busy"}, busy_ok, 1);
        tick(1);
        check({tag, "_idle_after"}, {if_a.in_ready, if_a.out_valid}, 2'b10);
    endtask

    initial begin
        int  cyc;
        bit  busy_ok;
        bit  stable;
        bit  seen;
        int  lat_b, lat_c;
        int  cnt_b, cnt_c;

        rst_n = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_zeros = 1'b0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_zeros = 1'b0; if_b.out_ready = 1'b1;
        if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_zeros = 1'b0; if_c.out_ready = 1'b1;
`ifdef POPCOUNT_SEQ_ACCUM_EN
        acc_clr_a = 1'b0; acc_clr_b = 1'b0; acc_clr_c = 1'b0;
`endif
        #3;
        check("reset_a", {if_a.in_ready, if_a.out_valid, if_a.out_count}, {1'b1, 1'b0, 6'd0});
        check("reset_c", {if_c.in_ready, if_c.out_valid, if_c.out_count}, {1'b1, 1'b0, 4'd0});
`ifdef POPCOUNT_SEQ_ACCUM_EN
        check("reset_acc_a", acc_total_a, 0);
        check("reset_acc_c", acc_total_c, 0);
`endif
        tick(2);

        // Release and offer a word at once: it must be taken on the very next edge.
        rst_n = 1'b1;
        run_a(32'hDB00_00E2, 1'b0, 10, "first_word");
        run_a(32'hFFFF_FFFF, 1'b0, 32, "ones_all");
        run_a(32'h0000_0000, 1'b1, 32, "zeros_all");
        run_a(32'h0000_0000, 1'b0, 0,  "ones_none");
        run_a(32'h8000_0001, 1'b1, 30, "zeros_mix");

        // Consumer stall while the producer keeps offering a new word.
        if_a.out_ready = 1'b0;
        start_a(32'h0000_00FF, 1'b0);
        wait_done_a(cyc, busy_ok);
        check("stall_latency", cyc, 4);
        check("stall_count", if_a.out_count, 8);
        if_a.in_valid = 1'b1;
        if_a.in_data  = 32'hFFFF_FFFF;
        if_a.in_zeros = 1'b0;
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (!if_a.out_valid || if_a.in_ready || if_a.out_count != 8) stable = 1'b0;
        end
        check("stall_hold", stable, 1);
        if_a.out_ready = 1'b1;
        tick(1);
        check("stall_release", {if_a.in_ready, if_a.out_valid}, 2'b10);
        tick(1);
        if_a.in_valid = 1'b0;
        if_a.in_data  = '0;
        wait_done_a(cyc, busy_ok);
        check("after_stall_latency", cyc, 4);
        check("after_stall_count", if_a.out_count, 32);
        tick(1);

        // Asynchronous reset in the middle of counting.
        start_a(32'hFFFF_FFFF, 1'b0);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {if_a.in_ready, if_a.out_valid, if_a.out_count}, {1'b1, 1'b0, 6'd0});
        tick(1);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick(1);
            if (if_a.out_valid) seen = 1'b1;
        end
        check("rst_no_out", seen, 0);
        run_a(32'h0000_0F0F, 1'b0, 8, "post_rst");

        // Narrow instances: one bit per cycle versus the whole word in one cycle.
        if_b.in_valid = 1'b1; if_b.in_data = 8'b1101_1011; if_b.in_zeros = 1'b0;
        if_c.in_valid = 1'b1; if_c.in_data = 8'b1101_1011; if_c.in_zeros = 1'b0;
        tick(1);
        if_b.in_valid = 1'b0; if_b.in_data = '0;
        if_c.in_valid = 1'b0; if_c.in_data = '0;
        lat_b = 0; lat_c = 0; cnt_b = -1; cnt_c = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (lat_b == 0 && if_b.out_valid) begin lat_b = i; cnt_b = int'(if_b.out_count); end
            if (lat_c == 0 && if_c.out_valid) begin lat_c = i; cnt_c = int'(if_c.out_count); end
        end
        check("w8c1_latency", lat_b, 8);
        check("w8c1_count", cnt_b, 6);
        check("w8c8_latency", lat_c, 1);
        check("w8c8_count", cnt_c, 6);

`ifdef POPCOUNT_SEQ_ACCUM_EN
        check("acc_first", acc_total_c, 6);
        acc_clr_c = 1'b1;
        tick(1);
        acc_clr_c = 1'b0;
        check("acc_clear", acc_total_c, 0);
        if_c.in_valid = 1'b1;
        if_c.in_data  = 8'hFF;
        tick(120);
        if_c.in_valid = 1'b0;
        tick(3);
        check("acc_saturate", acc_total_c, 8'hFF);
        if_c.in_valid = 1'b1;
        if_c.in_data  = 8'h03;
        tick(1);
        if_c.in_valid = 1'b0;
        tick(1);
        check("acc_c03_done", if_c.out_valid, 1);
        acc_clr_c = 1'b1;
        tick(1);
        acc_clr_c = 1'b0;
        check("acc_clr_load", acc_total_c, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
